mem_stage: RTL and testbench

//  Memory stage directly downstream of the execute stage (ALU + PC adder). Consumes the ALU result as either a

---
 rtl/mem_stage_if.sv | 44 ++++
 rtl/mem_stage.sv | 198 +++++++++++++++++++
 tb/tb_mem_stage.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Bundles the EX-side, data-memory and writeback signals of the memory stage.
// The stage itself connects through the slave modport.
interface mem_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
);
  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] ex_store_data;
  logic [4:0]        ex_rd;
  logic [1:0]        ex_memop;
  logic [1:0]        ex_size;
  logic              ex_unsigned;
  logic              ex_regwrite;

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [3:0]        dmem_be;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_regwrite;
  logic              misalign;

  modport slave (
    input  ex_valid, ex_result, ex_store_data, ex_rd, ex_memop, ex_size, ex_unsigned,
           ex_regwrite, dmem_ack, dmem_rdata,
    output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           wb_valid, wb_rd, wb_data, wb_regwrite, misalign
  );

  modport master (
    output ex_valid, ex_result, ex_store_data, ex_rd, ex_memop, ex_size, ex_unsigned,
           ex_regwrite, dmem_ack, dmem_rdata,
    input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           wb_valid, wb_rd, wb_data, wb_regwrite, misalign
  );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results through or performs one load/store over a
// req/ack data-memory port, then emits a single registered writeback pulse.
module mem_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
) (
  input logic       clk,
  input logic       rst_n,
  input logic       flush,
  mem_stage_if.slave bus
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StAccess = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              flush_q, flush_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lsb_q, lsb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [4:0]        rd_q, rd_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              rw_q, rw_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic              misalign_q, misalign_d;

  logic              accept, is_load, is_store, is_mem, misal;
  logic [1:0]        ex_lsb;
  logic [DATA_W-1:0] store_wdata, load_shifted, load_data;
  logic [3:0]        store_be;

  assign ex_lsb   = bus.ex_result[1:0];
  assign accept   = bus.ex_valid & bus.ex_ready & ~flush;
  assign is_load  = (bus.ex_memop == 2'b01);
  assign is_store = (bus.ex_memop == 2'b10);
  assign is_mem   = is_load | is_store;

  // Bytes are always aligned; size 2'b11 behaves as a word.
  always_comb begin
    misal = 1'b0;
    if (bus.ex_size == 2'b01)      misal = ex_lsb[0];
    else if (bus.ex_size[1])       misal = (ex_lsb != 2'b00);
  end

  always_comb begin
    case (bus.ex_size)
      2'b00: begin
        store_wdata = {4{bus.ex_store_data[7:0]}};
        store_be    = 4'b0001 << ex_lsb;
      end
      2'b01: begin
        store_wdata = {2{bus.ex_store_data[15:0]}};
        store_be    = 4'b0011 << ex_lsb;
      end
      default: begin
        store_wdata = bus.ex_store_data;
        store_be    = 4'b1111;
      end
    endcase
  end

  assign load_shifted = bus.dmem_rdata >> {lsb_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_data = uns_q ? {{(DATA_W-8){1'b0}}, load_shifted[7:0]}
                                 : {{(DATA_W-8){load_shifted[7]}}, load_shifted[7:0]};
      2'b01:   load_data = uns_q ? {{(DATA_W-16){1'b0}}, load_shifted[15:0]}
                                 : {{(DATA_W-16){load_shifted[15]}}, load_shifted[15:0]};
      default: load_data = bus.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    flush_d       = flush_q;
    we_d          = we_q;
    addr_d        = addr_q;
    lsb_d         = lsb_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    rd_d          = rd_q;
    size_d        = size_q;
    uns_d         = uns_q;
    rw_d          = rw_q;
    wb_valid_d    = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    wb_regwrite_d = wb_regwrite_q;
    misalign_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_d    = 1'b1;
            wb_rd_d       = bus.ex_rd;
            wb_data_d     = bus.ex_result;
            wb_regwrite_d = bus.ex_regwrite & (bus.ex_rd != 5'd0);
          end else if (misal) begin
            wb_valid_d    = 1'b1;
            wb_rd_d       = bus.ex_rd;
            wb_data_d     = '0;
            wb_regwrite_d = 1'b0;
            misalign_d    = 1'b1;
          end else begin
            state_d = StAccess;
            flush_d = 1'b0;
            we_d    = is_store;
            addr_d  = {bus.ex_result[ADDR_W-1:2], 2'b00};
            lsb_d   = ex_lsb;
            wdata_d = store_wdata;
            be_d    = is_store ? store_be : 4'b0000;
            rd_d    = bus.ex_rd;
            size_d  = bus.ex_size;
            uns_d   = bus.ex_unsigned;
            rw_d    = bus.ex_regwrite;
          end
        end
      end
      StAccess: begin
        // A flush cannot abandon the bus; it only suppresses the writeback.
        flush_d = flush_q | flush;
        if (bus.dmem_ack) begin
          state_d = StIdle;
          if (!(flush_q | flush)) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            if (we_q) begin
              wb_regwrite_d = 1'b0;
            end else begin
              wb_regwrite_d = rw_q & (rd_q != 5'd0);
              wb_data_d     = load_data;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      flush_q       <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      lsb_q         <= 2'b00;
      wdata_q       <= '0;
      be_q          <= 4'b0000;
      rd_q          <= 5'd0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      rw_q          <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= '0;
      wb_regwrite_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_q       <= flush_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      lsb_q         <= lsb_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      rd_q          <= rd_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      rw_q          <= rw_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      wb_regwrite_q <= wb_regwrite_d;
      misalign_q    <= misalign_d;
    end
  end

  assign bus.ex_ready    = (state_q == StIdle) & rst_n;
  assign bus.dmem_req    = (state_q == StAccess);
  assign bus.dmem_we     = we_q;
  assign bus.dmem_addr   = addr_q;
  assign bus.dmem_wdata  = wdata_q;
  assign bus.dmem_be     = be_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_regwrite = wb_regwrite_q;
  assign bus.misalign    = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table driven through EX, writeback checked by a queue
// scoreboard, plus hand sequences for flush and mid-access reset.
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  mem_stage_if #(.DATA_W(32), .ADDR_W(12)) bus ();

  mem_stage #(.DATA_W(32), .ADDR_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  memop;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] result;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] rdata;
    int          delay;
    logic        exp_req;
    logic        exp_we;
    logic [11:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_rw;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic        chk_data;
    logic [31:0] data;
    logic        rw;
    logic        mis;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Writeback scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.wb_valid) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        wb_exp_t e;
        e = sb_q.pop_front();
        check("wb_regwrite", {31'd0, bus.wb_regwrite}, {31'd0, e.rw});
        check("wb_misalign", {31'd0, bus.misalign}, {31'd0, e.mis});
        if (e.chk_data) check("wb_data", bus.wb_data, e.data);
        if (e.rw) check("wb_rd", {27'd0, bus.wb_rd}, {27'd0, e.rd});
      end
    end
  end

  task automatic drive_ex(input vec_t v);
    bus.ex_valid      = 1'b1;
    bus.ex_memop      = v.memop;
    bus.ex_size       = v.size;
    bus.ex_unsigned   = v.uns;
    bus.ex_result     = v.result;
    bus.ex_store_data = v.sdata;
    bus.ex_rd         = v.rd;
    bus.ex_regwrite   = v.rw;
  endtask

  // Called and returns at a negedge.
  task automatic run_vec(input vec_t v);
    wb_exp_t e;
    int k;
    k = 0;
    while (!bus.ex_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ex_ready_wait", {31'd0, bus.ex_ready}, 32'd1);
    drive_ex(v);
    e.rd = v.rd; e.chk_data = v.chk_data; e.data = v.exp_data; e.rw = v.exp_rw; e.mis = v.exp_mis;
    sb_q.push_back(e);
    @(posedge clk); #1 bus.ex_valid = 1'b0;
    @(negedge clk);
    if (!v.exp_req) begin
      check("no_req", {31'd0, bus.dmem_req}, 32'd0);
      check("wb_latency1", {31'd0, bus.wb_valid}, 32'd1);
    end else begin
      check("req", {31'd0, bus.dmem_req}, 32'd1);
      check("we", {31'd0, bus.dmem_we}, {31'd0, v.exp_we});
      check("addr", {20'd0, bus.dmem_addr}, {20'd0, v.exp_addr});
      check("be", {28'd0, bus.dmem_be}, {28'd0, v.exp_be});
      if (v.exp_we) check("wdata", bus.dmem_wdata, v.exp_wdata);
      for (int i = 0; i < v.delay; i++) begin
        @(negedge clk);
        check("req_held", {31'd0, bus.dmem_req}, 32'd1);
        check("addr_held", {20'd0, bus.dmem_addr}, {20'd0, v.exp_addr});
        check("wb_early", {31'd0, bus.wb_valid}, 32'd0);
      end
      bus.dmem_ack   = 1'b1;
      bus.dmem_rdata = v.rdata;
      @(posedge clk); #1;
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = 32'd0;
      @(negedge clk);
      check("wb_after_ack", {31'd0, bus.wb_valid}, 32'd1);
      check("req_dropped", {31'd0, bus.dmem_req}, 32'd0);
    end
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] memop, input logic [1:0] size, input logic uns,
                              input logic [31:0] result, input logic [31:0] sdata,
                              input logic [4:0] rd, input logic rw, input logic [31:0] rdata,
                              input int delay, input logic req, input logic [11:0] addr,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input logic chk, input logic [31:0] data, input logic erw,
                              input logic mis);
    vec_t v;
    v.memop = memop; v.size = size; v.uns = uns; v.result = result; v.sdata = sdata;
    v.rd = rd; v.rw = rw; v.rdata = rdata; v.delay = delay; v.exp_req = req;
    v.exp_we = (memop == 2'b10); v.exp_addr = addr; v.exp_be = be; v.exp_wdata = wdata;
    v.chk_data = chk; v.exp_data = data; v.exp_rw = erw; v.exp_mis = mis;
    return v;
  endfunction

  initial begin
    vec_t v;
    wb_exp_t e;
    rst_n = 1'b0; flush = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_result = '0; bus.ex_store_data = '0; bus.ex_rd = '0;
    bus.ex_memop = '0; bus.ex_size = '0; bus.ex_unsigned = 1'b0; bus.ex_regwrite = 1'b0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;

    //          memop  size  u  result        sdata         rd rw rdata         dly req addr    be
    //          wdata         chk data          rw mis
    vecs.push_back(mk(2'b00, 2'b10, 0, 32'h0000_1234, 0, 5, 1, 0, 0, 0, 0, 0,
                      0, 1, 32'h0000_1234, 1, 0));
    vecs.push_back(mk(2'b00, 2'b10, 0, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0, 0, 0,
                      0, 1, 32'hDEAD_BEEF, 0, 0));
    vecs.push_back(mk(2'b11, 2'b00, 0, 32'h0000_0055, 0, 7, 1, 0, 0, 0, 0, 0,
                      0, 1, 32'h0000_0055, 1, 0));
    vecs.push_back(mk(2'b10, 2'b00, 0, 32'h0000_0103, 32'h0000_00AB, 3, 1, 0, 3, 1, 12'h100,
                      4'b1000, 32'hABAB_ABAB, 0, 0, 0, 0));
    vecs.push_back(mk(2'b10, 2'b01, 0, 32'hFFFF_F102, 32'h1234_CDEF, 3, 1, 0, 0, 1, 12'h100,
                      4'b1100, 32'hCDEF_CDEF, 0, 0, 0, 0));
    vecs.push_back(mk(2'b10, 2'b10, 0, 32'h0000_0208, 32'hCAFE_F00D, 3, 0, 0, 1, 1, 12'h208,
                      4'b1111, 32'hCAFE_F00D, 0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 2'b00, 0, 32'h0000_0002, 0, 4, 1, 32'h0080_0000, 2, 1, 12'h000,
                      4'b0000, 0, 1, 32'hFFFF_FF80, 1, 0));
    vecs.push_back(mk(2'b01, 2'b00, 1, 32'h0000_0002, 0, 4, 1, 32'h0080_0000, 0, 1, 12'h000,
                      4'b0000, 0, 1, 32'h0000_0080, 1, 0));
    vecs.push_back(mk(2'b01, 2'b01, 0, 32'h0000_0002, 0, 6, 1, 32'h0080_0000, 1, 1, 12'h000,
                      4'b0000, 0, 1, 32'h0000_0080, 1, 0));
    vecs.push_back(mk(2'b01, 2'b01, 0, 32'h0000_0010, 0, 6, 1, 32'h0000_8001, 0, 1, 12'h010,
                      4'b0000, 0, 1, 32'hFFFF_8001, 1, 0));
    vecs.push_back(mk(2'b01, 2'b01, 1, 32'h0000_0010, 0, 6, 1, 32'h0000_8001, 0, 1, 12'h010,
                      4'b0000, 0, 1, 32'h0000_8001, 1, 0));
    vecs.push_back(mk(2'b01, 2'b00, 0, 32'h0000_0023, 0, 9, 1, 32'h7F00_0000, 0, 1, 12'h020,
                      4'b0000, 0, 1, 32'h0000_007F, 1, 0));
    vecs.push_back(mk(2'b01, 2'b11, 0, 32'h0000_0004, 0, 8, 1, 32'h89AB_CDEF, 2, 1, 12'h004,
                      4'b0000, 0, 1, 32'h89AB_CDEF, 1, 0));
    vecs.push_back(mk(2'b01, 2'b10, 0, 32'h0000_0008, 0, 0, 1, 32'h1111_2222, 0, 1, 12'h008,
                      4'b0000, 0, 1, 32'h1111_2222, 0, 0));
    vecs.push_back(mk(2'b01, 2'b10, 0, 32'h0000_0006, 0, 8, 1, 0, 0, 0, 0, 0,
                      0, 1, 32'h0000_0000, 0, 1));
    vecs.push_back(mk(2'b10, 2'b01, 0, 32'h0000_0001, 32'h5555, 8, 1, 0, 0, 0, 0, 0,
                      0, 1, 32'h0000_0000, 0, 1));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    check("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_be", {28'd0, bus.dmem_be}, 32'd0);
    check("rst_misalign", {31'd0, bus.misalign}, 32'd0);
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back ALU ops with ex_valid held.
    v = vecs[0];
    drive_ex(v);
    e.rd = 5; e.chk_data = 1; e.data = 32'h0000_1234; e.rw = 1; e.mis = 0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.ex_result = 32'h0000_4321; bus.ex_rd = 5'd12;
    e.rd = 12; e.data = 32'h0000_4321;
    sb_q.push_back(e);
    @(posedge clk); #1 bus.ex_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Flush in IDLE discards the same-cycle transfer.
    v = vecs[6];
    drive_ex(v);
    flush = 1'b1;
    @(posedge clk); #1;
    bus.ex_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush_req", {31'd0, bus.dmem_req}, 32'd0);
    check("idle_flush_wb", {31'd0, bus.wb_valid}, 32'd0);

    // Flush while waiting on ack: bus held until ack, no writeback.
    v = vecs[12];
    drive_ex(v);
    @(posedge clk); #1 bus.ex_valid = 1'b0;
    @(negedge clk);
    check("fl_req", {31'd0, bus.dmem_req}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("fl_req_held", {31'd0, bus.dmem_req}, 32'd1);
    check("fl_not_ready", {31'd0, bus.ex_ready}, 32'd0);
    @(negedge clk);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1234_5678;
    @(posedge clk); #1 bus.dmem_ack = 1'b0;
    @(negedge clk);
    check("fl_no_wb", {31'd0, bus.wb_valid}, 32'd0);
    check("fl_req_drop", {31'd0, bus.dmem_req}, 32'd0);
    check("fl_ready", {31'd0, bus.ex_ready}, 32'd1);

    // Reset in the middle of an access.
    drive_ex(v);
    @(posedge clk); #1 bus.ex_valid = 1'b0;
    @(negedge clk);
    check("rr_req", {31'd0, bus.dmem_req}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rr_req_drop", {31'd0, bus.dmem_req}, 32'd0);
    check("rr_wb", {31'd0, bus.wb_valid}, 32'd0);
    rst_n = 1'b1;
    #1 check("rr_ready", {31'd0, bus.ex_ready}, 32'd1);
    repeat (2) @(negedge clk);

    // A plain op still works after the reset.
    run_vec(vecs[2]);
    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
